// File: rtl/v_shift_sequencer_if.sv
// ---------------------------------------------------------------------------
// v_shift_sequencer_if
// Request/response bundle for v_shift_sequencer.
//   di, amt, in_val, in_rdy   : request handshake (operand + total shift amount)
//   so, out_val, out_rdy      : result handshake
//   step_sel, busy            : status (stage code applied this cycle, activity)
//   rot                       : rotate select, present only with SEQ_ROTATE_EN
// Modports: master = requester/consumer side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface v_shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) ();
  logic [WIDTH-1:0] di;
  logic [AMT_W-1:0] amt;
  logic             in_val;
  logic             in_rdy;
  logic [WIDTH-1:0] so;
  logic             out_val;
  logic             out_rdy;
  logic [1:0]       step_sel;
  logic             busy;
`ifdef SEQ_ROTATE_EN
  logic             rot;

  modport master (
    output di, amt, in_val, out_rdy, rot,
    input  in_rdy, so, out_val, step_sel, busy
  );

  modport slave (
    input  di, amt, in_val, out_rdy, rot,
    output in_rdy, so, out_val, step_sel, busy
  );
`else
  modport master (
    output di, amt, in_val, out_rdy,
    input  in_rdy, so, out_val, step_sel, busy
  );

  modport slave (
    input  di, amt, in_val, out_rdy,
    output in_rdy, so, out_val, step_sel, busy
  );
`endif
endinterface

// File: rtl/v_shift_sequencer.sv
// ---------------------------------------------------------------------------
// v_shift_sequencer
// Multi-cycle left shifter built around one stage that moves 0..3 positions
// per cycle. An operand and total amount are accepted over a valid/ready
// handshake, the stage is sequenced min(rem,3) positions per cycle, and the
// result is returned over a second valid/ready handshake.
//
// Ports:
//   c    : clock, rising edge
//   clr  : asynchronous active-high reset
//   bus  : v_shift_sequencer_if.slave (di, amt, in_val, in_rdy, so, out_val,
//          out_rdy, step_sel, busy, and rot when rotate is enabled)
//
// Build option: define SEQ_ROTATE_EN to add the rot request field, which
// turns every step into a left rotate instead of a zero-fill shift.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request (in_rdy=1)
// SHIFT | applying one stage step per cycle until rem reaches 0
// DONE  | result presented (out_val=1) until out_rdy
// ---------------------------------------------------------------------------
module v_shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input logic             c,
  input logic             clr,
  v_shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Stage codes are deliberately non-monotonic: 10 means 3, 11 means 2.
  localparam logic [1:0] SEL_0 = 2'b00;
  localparam logic [1:0] SEL_1 = 2'b01;
  localparam logic [1:0] SEL_3 = 2'b10;
  localparam logic [1:0] SEL_2 = 2'b11;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data, data_nxt;
  logic [AMT_W-1:0] rem, rem_nxt;
  logic [1:0]       sel;
  logic [1:0]       step;
  logic [AMT_W-1:0] rem_after;
  logic [WIDTH-1:0] stage_out;

`ifdef SEQ_ROTATE_EN
  logic rot_q, rot_nxt;
`endif

  function automatic logic [1:0] sel_to_step(input logic [1:0] code);
    case (code)
      SEL_1:   sel_to_step = 2'd1;
      SEL_2:   sel_to_step = 2'd2;
      SEL_3:   sel_to_step = 2'd3;
      default: sel_to_step = 2'd0;
    endcase
  endfunction

  // Single shift stage. Rotation is taken from the upper half of the doubled
  // word so bits leaving the MSB re-enter at the LSB.
  function automatic logic [WIDTH-1:0] shift_stage(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       n,
    input logic             rotate
  );
    logic [2*WIDTH-1:0] dbl;
    dbl = {d, d} << n;
    if (rotate) shift_stage = dbl[2*WIDTH-1:WIDTH];
    else        shift_stage = d << n;
  endfunction

  // Stage select derived from the remaining count; only meaningful in SHIFT.
  always_comb begin
    sel = SEL_0;
    if (state == S_SHIFT) begin
      if (rem >= AMT_W'(3))      sel = SEL_3;
      else if (rem == AMT_W'(2)) sel = SEL_2;
      else if (rem == AMT_W'(1)) sel = SEL_1;
      else                       sel = SEL_0;
    end
  end

  assign step      = sel_to_step(sel);
  assign rem_after = rem - AMT_W'(step);

`ifdef SEQ_ROTATE_EN
  assign stage_out = shift_stage(data, step, rot_q);
`else
  assign stage_out = shift_stage(data, step, 1'b0);
`endif

  always_ff @(posedge c or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      data  <= '0;
      rem   <= '0;
`ifdef SEQ_ROTATE_EN
      rot_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      data  <= data_nxt;
      rem   <= rem_nxt;
`ifdef SEQ_ROTATE_EN
      rot_q <= rot_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = data;
    rem_nxt   = rem;
`ifdef SEQ_ROTATE_EN
    rot_nxt   = rot_q;
`endif
    case (state)
      S_IDLE: begin
        if (bus.in_val) begin
          data_nxt = bus.di;
          rem_nxt  = bus.amt;
`ifdef SEQ_ROTATE_EN
          rot_nxt  = bus.rot;
`endif
          state_nxt = (bus.amt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        // No early exit for large amounts: every step is executed.
        data_nxt = stage_out;
        rem_nxt  = rem_after;
        if (rem_after == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.out_rdy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.in_rdy   = (state == S_IDLE);
  assign bus.out_val  = (state == S_DONE);
  assign bus.busy     = (state != S_IDLE);
  assign bus.step_sel = sel;
  assign bus.so       = (state == S_DONE) ? data : '0;

endmodule

// File: tb/tb_v_shift_sequencer.sv
module tb_v_shift_sequencer;
  localparam int W = 8;
  localparam int A = 4;

  logic c;
  logic clr;
  int   checks = 0;
  int   errors = 0;

  v_shift_sequencer_if #(.WIDTH(W), .AMT_W(A)) bus ();

  v_shift_sequencer #(.WIDTH(W), .AMT_W(A)) dut (
    .c   (c),
    .clr (clr),
    .bus (bus.slave)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 waiting for a request, 1 stepping, 2 result offered
  int         m_phase;
  int         m_codes[$];
  logic [7:0] m_res;

  function automatic int code_of(input int s);
    if (s == 3) return 2;
    if (s == 2) return 3;
    return s;
  endfunction

  function automatic logic [7:0] ref_result(input logic [7:0] d, input int amt, input logic rotate);
    int v, k;
    v = int'(d);
    if (rotate) begin
      k = amt % W;
      return 8'(((v << k) | (v >> (W - k))) & 255);
    end
    if (amt >= W) return 8'h00;
    return 8'((v << amt) & 255);
  endfunction

  always @(posedge c or posedge clr) begin
    if (clr) begin
      m_phase = 0;
      m_codes.delete();
      m_res = 8'h00;
    end else begin
      case (m_phase)
        0: if (bus.in_val) begin
          int r;
          logic rr;
          rr = 1'b0;
`ifdef SEQ_ROTATE_EN
          rr = bus.rot;
`endif
          r = int'(bus.amt);
          m_res = ref_result(bus.di, r, rr);
          m_codes.delete();
          while (r > 0) begin
            int s;
            s = (r > 3) ? 3 : r;
            m_codes.push_back(code_of(s));
            r -= s;
          end
          m_phase = (m_codes.size() == 0) ? 2 : 1;
        end
        1: begin
          void'(m_codes.pop_front());
          if (m_codes.size() == 0) m_phase = 2;
        end
        default: if (bus.out_rdy) m_phase = 0;
      endcase
    end
  end

  always @(negedge c) begin
    if (!clr) begin
      case (m_phase)
        0: begin
          chk("idle_in_rdy", 32'(bus.in_rdy), 1);
          chk("idle_out_val", 32'(bus.out_val), 0);
          chk("idle_busy", 32'(bus.busy), 0);
          chk("idle_step_sel", 32'(bus.step_sel), 0);
        end
        1: begin
          chk("shift_step_sel", 32'(bus.step_sel), 32'(m_codes[0]));
          chk("shift_out_val", 32'(bus.out_val), 0);
          chk("shift_busy", 32'(bus.busy), 1);
          chk("shift_in_rdy", 32'(bus.in_rdy), 0);
        end
        default: begin
          chk("done_out_val", 32'(bus.out_val), 1);
          chk("done_so", 32'(bus.so), 32'(m_res));
          chk("done_busy", 32'(bus.busy), 1);
          chk("done_in_rdy", 32'(bus.in_rdy), 0);
          chk("done_step_sel", 32'(bus.step_sel), 0);
        end
      endcase
    end
  end

  // ---------------- directed transaction with literal expectations ----------------
  task automatic run_txn(input string nm, input logic [7:0] d, input logic [3:0] a, input logic r,
                         input logic [7:0] exp_so, input logic [15:0] exp_codes, input int exp_edges);
    int g;
    int edges;
    logic [15:0] codes;
    @(negedge c);
    g = 0;
    while (!bus.in_rdy && g < 50) begin
      @(negedge c);
      g++;
    end
    chk({nm, "_accept_wait"}, 32'(bus.in_rdy), 1);
    bus.di = d;
    bus.amt = a;
    bus.in_val = 1'b1;
`ifdef SEQ_ROTATE_EN
    bus.rot = r;
`else
    if (r) $display("note: rotate request ignored in this build");
`endif
    @(negedge c);
    bus.in_val = 1'b0;
    edges = 1;
    codes = 16'h0;
    while (!bus.out_val && edges < 40) begin
      codes = {codes[13:0], bus.step_sel};
      @(negedge c);
      edges++;
    end
    chk({nm, "_latency"}, 32'(edges), 32'(exp_edges));
    chk({nm, "_codes"}, 32'(codes), 32'(exp_codes));
    chk({nm, "_so"}, 32'(bus.so), 32'(exp_so));
  endtask

  initial begin
    clr = 1'b1;
    bus.di = '0;
    bus.amt = '0;
    bus.in_val = 1'b0;
    bus.out_rdy = 1'b1;
`ifdef SEQ_ROTATE_EN
    bus.rot = 1'b0;
`endif
    #12;
    chk("rst_in_rdy", 32'(bus.in_rdy), 1);
    chk("rst_out_val", 32'(bus.out_val), 0);
    chk("rst_so", 32'(bus.so), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_step_sel", 32'(bus.step_sel), 0);
    @(negedge c);
    clr = 1'b0;

    run_txn("amt0",  8'hB5, 4'd0,  1'b0, 8'hB5, 16'h0000, 1);
    run_txn("amt5",  8'hB5, 4'd5,  1'b0, 8'hA0, 16'h000B, 3);
    run_txn("amt7",  8'hB5, 4'd7,  1'b0, 8'h80, 16'h0029, 4);
    run_txn("amt12", 8'hFF, 4'd12, 1'b0, 8'h00, 16'h00AA, 5);
`ifdef SEQ_ROTATE_EN
    run_txn("rot5",  8'hB5, 4'd5,  1'b1, 8'hB6, 16'h000B, 3);
`endif

    // Output stall with a competing request that must be ignored.
    @(negedge c);
    bus.out_rdy = 1'b0;
    run_txn("hold", 8'h3C, 4'd4, 1'b0, 8'hC0, 16'h0009, 3);
    for (int i = 0; i < 3; i++) begin
      chk("hold_so", 32'(bus.so), 32'h00C0);
      chk("hold_out_val", 32'(bus.out_val), 1);
      chk("hold_in_rdy", 32'(bus.in_rdy), 0);
      bus.di = 8'h11;
      bus.amt = 4'd1;
      bus.in_val = 1'b1;
      @(negedge c);
    end
    bus.out_rdy = 1'b1;
    @(negedge c);
    chk("post_hold_idle", 32'(bus.in_rdy), 1);
    chk("post_hold_out_val", 32'(bus.out_val), 0);
    @(negedge c);
    bus.in_val = 1'b0;
    chk("second_accepted", 32'(bus.busy), 1);
    @(negedge c);
    chk("second_out_val", 32'(bus.out_val), 1);
    chk("second_so", 32'(bus.so), 32'h0022);

    // Reset in the middle of a shift sequence.
    @(negedge c);
    bus.di = 8'hB5;
    bus.amt = 4'd9;
    bus.in_val = 1'b1;
    @(negedge c);
    bus.in_val = 1'b0;
    @(posedge c);
    #2 clr = 1'b1;
    #1;
    chk("clr_so", 32'(bus.so), 0);
    chk("clr_out_val", 32'(bus.out_val), 0);
    chk("clr_in_rdy", 32'(bus.in_rdy), 1);
    chk("clr_step_sel", 32'(bus.step_sel), 0);
    chk("clr_busy", 32'(bus.busy), 0);
    @(negedge c);
    clr = 1'b0;

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 600; n++) begin
      @(negedge c);
      bus.in_val  = 1'($urandom_range(0, 1));
      bus.di      = 8'($urandom);
      bus.amt     = 4'($urandom);
      bus.out_rdy = ($urandom_range(0, 3) != 0);
`ifdef SEQ_ROTATE_EN
      bus.rot     = 1'($urandom_range(0, 1));
`endif
    end
    @(negedge c);
    bus.in_val = 1'b0;
    bus.out_rdy = 1'b1;
    repeat (10) @(negedge c);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/v_shift_sequencer.md
Name: v_shift_sequencer

Overview:
- Multi-cycle logical left-shift controller built around a single per-cycle shift stage.
- The stage supports steps of 0, 1, 2 or 3 positions, selected by a 2-bit code with non-monotonic encoding: 00=0, 01=1, 10=3, 11=2.
- Accepts an operand and a total shift amount over a valid/ready handshake, then sequences the stage over several cycles.
- Returns the result over a second valid/ready handshake. Sits between a requester and a consumer in a generic datapath.

Parameters:
- WIDTH, 8, data width of operand and result.
- AMT_W, 4, width of total shift amount (0 to 2^AMT_W-1).

Ports:
- C  input  1  clock; all state changes on rising edge.
- CLR  input  1  asynchronous, active-high reset.
- DI  input  WIDTH  operand.
- AMT  input  AMT_W  total shift amount.
- IN_VAL  input  1  request valid.
- IN_RDY  output  1  request ready; high only in IDLE.
- SO  output  WIDTH  result; held stable while OUT_VAL=1.
- OUT_VAL  output  1  result valid.
- OUT_RDY  input  1  consumer ready.
- STEP_SEL  output  2  stage select code applied this cycle.
- BUSY  output  1  high in SHIFT or DONE.

Behaviour:
- Clock and reset: single clock C; CLR is asynchronous, active-high.
- CLR asserted, including mid-operation:
  - state=IDLE; data and remaining-count registers cleared to 0.
  - SO=0, OUT_VAL=0, STEP_SEL=2'b00, BUSY=0, IN_RDY=1.
  - Any in-flight request is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - IN_RDY=1.
  - On an edge with IN_VAL=1: load DATA<=DI and REM<=AMT.
  - If AMT=0, go to DONE; otherwise go to SHIFT.
- SHIFT:
  - step=min(REM,3).
  - STEP_SEL encodes step combinationally from REM: 3->10, 2->11, 1->01.
  - Each edge: DATA<=DATA<<step with zero fill; REM<=REM-step.
  - When REM-step=0, go to DONE.
  - IN_VAL is ignored.
- DONE:
  - OUT_VAL=1, SO=DATA.
  - On an edge with OUT_RDY=1: go to IDLE, OUT_VAL falls.
  - With OUT_RDY=0: SO and OUT_VAL hold indefinitely.
- Latency: with m=ceil(AMT/3), OUT_VAL rises after the (m+1)th edge counting the accepting edge.
  - AMT=0: OUT_VAL in the cycle right after acceptance.
- Throughput: no bypass; the next request is accepted at the earliest one edge after the output handshake (IDLE cycle required).
- Outside SHIFT: STEP_SEL=00.
- Amounts >= WIDTH: result is 0, but all m SHIFT cycles still execute; no early termination.
- IN_VAL and OUT_RDY are sampled only in their respective states; values in other states have no effect.

Optional Feature:
- Macro: SEQ_ROTATE_EN.
- When defined:
  - Adds input port ROT (1 bit), captured with the request.
  - ROT=1 makes every step a left rotate (bits leaving the MSB re-enter at the LSB) instead of a logical shift.
  - Amounts >= WIDTH wrap naturally through repeated steps.
  - ROT=0 behaves as logical shift.
- When undefined: ROT port is absent; behaviour is pure logical shift as above.

Test Plan:
- Reset release, then DI=8'hB5, AMT=0, IN_VAL pulse, OUT_RDY=1 -> OUT_VAL rises after 1 edge, SO=8'hB5, STEP_SEL stays 00.
- DI=8'hB5, AMT=5 -> STEP_SEL sequence 10 then 11; OUT_VAL after 3 edges; SO=8'hA0.
- DI=8'hB5, AMT=7 -> STEP_SEL 10, 10, 01; SO=8'h80.
- DI=8'hFF, AMT=12 -> four SHIFT cycles with STEP_SEL=10 each; SO=8'h00.
- AMT=4 with OUT_RDY held low for 3 cycles:
  - SO/OUT_VAL stable throughout, IN_RDY=0.
  - A second IN_VAL during that time is ignored.
  - After OUT_RDY=1, IDLE for one cycle, then the new request is accepted.
- CLR pulsed during SHIFT (AMT=9, after 1 step) -> immediate IDLE, SO=0, OUT_VAL=0, IN_RDY=1. With SEQ_ROTATE_EN: DI=8'hB5, AMT=5, ROT=1 -> SO=8'hB6.
